// File: rtl/free_list_if.sv
// ---------------------------------------------------------------------------
// free_list_if
//   Bundles the rename-side and commit-side signals of the physical register
//   free list into one interface.
//   Ports (signals):
//     hardware_scheduler_swap_pc  master->slave  thread swap, restore reset state
//     mispredict_flush            master->slave  squash speculative allocations
//     dequeue_req                 master->slave  rename consumes free_phys_reg
//     free_phys_reg   [PR_W]      slave->master  ID at the head of the list
//     free_avail                  slave->master  list non-empty
//     reg_freed                   master->slave  commit-side free pulse
//     liberated_phys_reg [PR_W]   master->slave  ID returned when reg_freed=1
//     free_count      [PTR_W]     slave->master  speculative free entries
//   Modports: master (core side), slave (free_list).
// ---------------------------------------------------------------------------
interface free_list_if #(
    parameter int NUM_REGS = 64
);
    localparam int PR_W  = $clog2(NUM_REGS);
    localparam int DEPTH = NUM_REGS - 32;
    localparam int PTR_W = $clog2(DEPTH) + 1;

    logic             hardware_scheduler_swap_pc;
    logic             mispredict_flush;
    logic             dequeue_req;
    logic [PR_W-1:0]  free_phys_reg;
    logic             free_avail;
    logic             reg_freed;
    logic [PR_W-1:0]  liberated_phys_reg;
    logic [PTR_W-1:0] free_count;

    modport master (
        output hardware_scheduler_swap_pc,
        output mispredict_flush,
        output dequeue_req,
        output reg_freed,
        output liberated_phys_reg,
        input  free_phys_reg,
        input  free_avail,
        input  free_count
    );

    modport slave (
        input  hardware_scheduler_swap_pc,
        input  mispredict_flush,
        input  dequeue_req,
        input  reg_freed,
        input  liberated_phys_reg,
        output free_phys_reg,
        output free_avail,
        output free_count
    );
endinterface

// File: rtl/free_list.sv
// ---------------------------------------------------------------------------
// free_list
//   Circular FIFO of unallocated physical register IDs for the OOO core.
//   Rename pops from the speculative head, commit pushes displaced mappings at
//   the tail, and a retire-side head allows single-cycle mispredict recovery.
//   Ports:
//     clk   in  clock, all state updates on posedge
//     rst   in  synchronous active-high reset
//     fl    free_list_if.slave (see free_list_if for signal list)
// ---------------------------------------------------------------------------
module free_list #(
    parameter int NUM_REGS = 64
) (
    input  logic          clk,
    input  logic          rst,
    free_list_if.slave    fl
);
    localparam int PR_W  = $clog2(NUM_REGS);
    localparam int DEPTH = NUM_REGS - 32;
    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = PTR_W - 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] retire_head_q, retire_head_d;
    logic [PTR_W-1:0] tail_q, tail_d;

    logic             reset_all;
    logic             empty;
    logic             full;
    logic             deq;
    logic             enq;
    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] tail_idx;
    logic [PR_W-1:0]  mem_rd [DEPTH];

    // A thread swap returns the list to exactly the post-reset state.
    assign reset_all = rst | fl.hardware_scheduler_swap_pc;

    assign head_idx = head_q[IDX_W-1:0];
    assign tail_idx = tail_q[IDX_W-1:0];
    assign empty    = (head_q == tail_q);
    assign full     = (head_idx == tail_idx) && (head_q[PTR_W-1] != tail_q[PTR_W-1]);

    // No bypass: a dequeue is only honoured against already-stored entries.
    assign deq = fl.dequeue_req && !empty && !fl.mispredict_flush;
    // A free into a full list is a double free and is dropped, unless the
    // same cycle pops the head entry and so makes room for it.
    assign enq = fl.reg_freed && (!full || deq);

    // Storage: one register per entry, reset to the identity IDs 32..63.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
        logic [PR_W-1:0] entry_q, entry_d;

        always_comb begin
            entry_d = entry_q;
            if (enq && (tail_idx == IDX_W'(gi))) begin
                entry_d = fl.liberated_phys_reg;
            end
        end

        always_ff @(posedge clk) begin
            if (reset_all) begin
                entry_q <= PR_W'(32 + gi);
            end else begin
                entry_q <= entry_d;
            end
        end

        assign mem_rd[gi] = entry_q;
    end

    always_comb begin
        retire_head_d = retire_head_q;
        tail_d        = tail_q;
        head_d        = head_q;
        // Each commit free retires exactly one earlier allocation.
        if (enq) begin
            retire_head_d = retire_head_q + PTR_W'(1);
            tail_d        = tail_q + PTR_W'(1);
        end
        // Flush restores to the retire head including this cycle's commit.
        if (fl.mispredict_flush) begin
            head_d = retire_head_d;
        end else if (deq) begin
            head_d = head_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset_all) begin
            head_q        <= '0;
            retire_head_q <= '0;
            tail_q        <= PTR_W'(DEPTH);
        end else begin
            head_q        <= head_d;
            retire_head_q <= retire_head_d;
            tail_q        <= tail_d;
        end
    end

    assign fl.free_phys_reg = mem_rd[head_idx];
    assign fl.free_avail    = !empty;
    assign fl.free_count    = tail_q - head_q;

    a_no_double_free : assert property (@(posedge clk) disable iff (reset_all)
        fl.reg_freed |-> (!full || deq));
    a_no_free_p0 : assert property (@(posedge clk) disable iff (reset_all)
        fl.reg_freed |-> (fl.liberated_phys_reg != '0));
endmodule

// File: tb/tb_free_list.sv
module tb_free_list;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    free_list_if #(.NUM_REGS(64)) fl_if ();

    free_list #(.NUM_REGS(64)) dut (
        .clk (clk),
        .rst (rst),
        .fl  (fl_if.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        fl_if.hardware_scheduler_swap_pc = 1'b0;
        fl_if.mispredict_flush           = 1'b0;
        fl_if.dequeue_req                = 1'b0;
        fl_if.reg_freed                  = 1'b0;
        fl_if.liberated_phys_reg         = '0;
    endtask

    task automatic do_reset();
        clr();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) begin
            fl_if.dequeue_req = 1'b1;
            step();
        end
        fl_if.dequeue_req = 1'b0;
    endtask

    initial begin
        clr();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_avail", 32'(fl_if.free_avail), 1);
        check("rst_id", 32'(fl_if.free_phys_reg), 32);
        check("rst_count", 32'(fl_if.free_count), 32);

        // 1: drain 32 IDs in order
        for (int i = 0; i < 32; i++) begin
            check($sformatf("t1_id%0d", i), 32'(fl_if.free_phys_reg), 32'(32 + i));
            fl_if.dequeue_req = 1'b1;
            step();
        end
        fl_if.dequeue_req = 1'b0;
        check("t1_avail", 32'(fl_if.free_avail), 0);
        check("t1_count", 32'(fl_if.free_count), 0);
        fl_if.dequeue_req = 1'b1;
        step();
        fl_if.dequeue_req = 1'b0;
        check("t1_empty_deq_count", 32'(fl_if.free_count), 0);

        // 2: free while empty with dequeue_req -> no bypass
        fl_if.dequeue_req        = 1'b1;
        fl_if.reg_freed          = 1'b1;
        fl_if.liberated_phys_reg = 6'd5;
        check("t2_avail_pre", 32'(fl_if.free_avail), 0);
        step();
        clr();
        check("t2_id", 32'(fl_if.free_phys_reg), 5);
        check("t2_avail", 32'(fl_if.free_avail), 1);
        check("t2_count", 32'(fl_if.free_count), 1);

        // 3: pop 3, free 7, flush with ignored dequeue_req
        do_reset();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t3_id%0d", i), 32'(fl_if.free_phys_reg), 32'(32 + i));
            fl_if.dequeue_req = 1'b1;
            step();
        end
        clr();
        fl_if.reg_freed          = 1'b1;
        fl_if.liberated_phys_reg = 6'd7;
        step();
        clr();
        check("t3_count_pre", 32'(fl_if.free_count), 30);
        check("t3_id_pre", 32'(fl_if.free_phys_reg), 35);
        fl_if.mispredict_flush = 1'b1;
        fl_if.dequeue_req      = 1'b1;
        step();
        clr();
        check("t3_flush_id", 32'(fl_if.free_phys_reg), 33);
        check("t3_flush_count", 32'(fl_if.free_count), 32);
        check("t3_flush_avail", 32'(fl_if.free_avail), 1);
        // flush with a same-cycle free: head follows retire_head + 1
        pop_n(2);
        fl_if.mispredict_flush   = 1'b1;
        fl_if.reg_freed          = 1'b1;
        fl_if.liberated_phys_reg = 6'd11;
        step();
        clr();
        check("t3_flush_enq_id", 32'(fl_if.free_phys_reg), 34);
        check("t3_flush_enq_count", 32'(fl_if.free_count), 32);

        // 4: simultaneous pop and free at count 10
        do_reset();
        pop_n(22);
        check("t4_count_pre", 32'(fl_if.free_count), 10);
        check("t4_id_pre", 32'(fl_if.free_phys_reg), 54);
        fl_if.dequeue_req        = 1'b1;
        fl_if.reg_freed          = 1'b1;
        fl_if.liberated_phys_reg = 6'd9;
        step();
        clr();
        check("t4_count", 32'(fl_if.free_count), 10);
        check("t4_id", 32'(fl_if.free_phys_reg), 55);
        pop_n(9);
        check("t4_landed_id", 32'(fl_if.free_phys_reg), 9);
        check("t4_landed_count", 32'(fl_if.free_count), 1);

        // 5: 40 pop/free pairs wrap the pointers
        do_reset();
        for (int k = 0; k < 40; k++) begin
            check($sformatf("t5_id%0d", k), 32'(fl_if.free_phys_reg),
                  (k < 32) ? 32'(32 + k) : 32'(k - 31));
            fl_if.dequeue_req        = 1'b1;
            fl_if.reg_freed          = 1'b1;
            fl_if.liberated_phys_reg = 6'(k + 1);
            step();
            check($sformatf("t5_count%0d", k), 32'(fl_if.free_count), 32);
        end
        clr();
        check("t5_id_after", 32'(fl_if.free_phys_reg), 9);

        // 6: thread swap mid-stream drops the same-cycle free
        do_reset();
        pop_n(2);
        check("t6_count_pre", 32'(fl_if.free_count), 30);
        fl_if.hardware_scheduler_swap_pc = 1'b1;
        fl_if.reg_freed                  = 1'b1;
        fl_if.liberated_phys_reg         = 6'd12;
        fl_if.dequeue_req                = 1'b1;
        step();
        clr();
        check("t6_id", 32'(fl_if.free_phys_reg), 32);
        check("t6_count", 32'(fl_if.free_count), 32);
        check("t6_avail", 32'(fl_if.free_avail), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
